dcache_controller: RTL and testbench

- Direct-mapped, write-through, no-write-allocate data cache.
- Sits between the memory stage of the pipelined core and the backing data memory.
- Acts as the responder to the core's load/store requests, stalling the pipeline on misses and stores.
- Acts as the initiator of a word-wide req/ack handshake to backing memory, used for line refills and write-through stores.

---
 rtl/dcache_pkg.sv | 27 ++
 rtl/dcache_controller_align.sv | 59 +++++
 rtl/dcache_controller.sv | 170 +++++++++++++++++
 tb/tb_dcache_controller.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// Shared definitions for the data cache controller.
// Holds the FSM state encoding, the funct3 access-size codes and the
// address-field widths of the default cache geometry.
package dcache_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REFILL = 2'd1,
        WRITE  = 2'd2
    } state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int DEF_SETS           = 16;
    localparam int DEF_WORDS_PER_LINE = 4;
    localparam int DEF_ADDR_WIDTH     = 32;

    localparam int OFFSET_BITS = 2;
    localparam int WORD_BITS   = $clog2(DEF_WORDS_PER_LINE);
    localparam int INDEX_BITS  = $clog2(DEF_SETS);
    localparam int TAG_BITS    = DEF_ADDR_WIDTH - OFFSET_BITS - WORD_BITS - INDEX_BITS;

endpackage

// File: rtl/dcache_controller_align.sv
// Combinational load/store lane alignment.
// Ports:
//   funct3     access size/signedness code
//   byte_off   addr[1:0] of the access
//   store_data right-aligned store data from the core
//   read_word  cached word being loaded
//   wstrb      byte enables for the store
//   wdata      store data replicated into every lane
//   load_data  extracted and sign/zero-extended load result
module load_store_align
    import dcache_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  byte_off,
    input  logic [31:0] store_data,
    input  logic [31:0] read_word,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata,
    output logic [31:0] load_data
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic        sign_ext;

    always_comb begin
        case (byte_off)
            2'd0:    sel_byte = read_word[7:0];
            2'd1:    sel_byte = read_word[15:8];
            2'd2:    sel_byte = read_word[23:16];
            default: sel_byte = read_word[31:24];
        endcase
        // Halfword accesses ignore addr[0].
        sel_half = byte_off[1] ? read_word[31:16] : read_word[15:0];
        // funct3[2] marks the unsigned variants (LBU/LHU).
        sign_ext = ~funct3[2];

        // Size decode on funct3[1:0]: anything that is not byte or half,
        // including the undefined codes, behaves as a full word.
        case (funct3[1:0])
            F3_B[1:0]: begin
                wstrb     = 4'b0001 << byte_off;
                wdata     = {4{store_data[7:0]}};
                load_data = {{24{sign_ext & sel_byte[7]}}, sel_byte};
            end
            F3_H[1:0]: begin
                wstrb     = 4'b0011 << {byte_off[1], 1'b0};
                wdata     = {2{store_data[15:0]}};
                load_data = {{16{sign_ext & sel_half[15]}}, sel_half};
            end
            default: begin
                wstrb     = 4'b1111;
                wdata     = store_data;
                load_data = read_word;
            end
        endcase
    end

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped, write-through, no-write-allocate data cache between the
// core memory stage and a word-wide req/ack backing memory.
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   cpu_req/we/ctrl/addr/wdata       core access (held stable while stall=1)
//   cpu_rdata, stall                 load result, pipeline freeze
//   mem_req/we/addr/wdata/wstrb      backing memory request
//   mem_ack, mem_rdata               one-cycle completion with read data
//
// state  | meaning
// IDLE   | serve load hits; decide refill or write-through
// REFILL | fetch line words 0..WORDS_PER_LINE-1 in order
// WRITE  | single write-through of the held store
module dcache_controller
    import dcache_pkg::*;
#(
    parameter int SETS           = 1 << INDEX_BITS,
    parameter int WORDS_PER_LINE = 1 << WORD_BITS,
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = OFFSET_BITS + WORD_BITS + INDEX_BITS + TAG_BITS
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [2:0]            cpu_ctrl,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic                  stall,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [3:0]            mem_wstrb,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam int WSEL_BITS = $clog2(WORDS_PER_LINE);
    localparam int SET_BITS  = $clog2(SETS);
    localparam int TAG_W     = ADDR_WIDTH - OFFSET_BITS - WSEL_BITS - SET_BITS;

    logic [WSEL_BITS-1:0]  word_sel;
    logic [SET_BITS-1:0]   set_idx;
    logic [TAG_W-1:0]      addr_tag;

    logic [SETS-1:0]       valid_q;
    logic [TAG_W-1:0]      tag_q  [SETS];
    logic [DATA_WIDTH-1:0] data_q [SETS][WORDS_PER_LINE];

    state_t                state_q, state_d;
    logic [WSEL_BITS-1:0]  fill_cnt_q;

    logic                  hit;
    logic                  last_word;
    logic [DATA_WIDTH-1:0] read_word;
    logic [3:0]            st_wstrb;
    logic [DATA_WIDTH-1:0] st_wdata;
    logic [DATA_WIDTH-1:0] ld_data;

    assign word_sel  = cpu_addr[OFFSET_BITS +: WSEL_BITS];
    assign set_idx   = cpu_addr[OFFSET_BITS + WSEL_BITS +: SET_BITS];
    assign addr_tag  = cpu_addr[ADDR_WIDTH-1 -: TAG_W];
    assign hit       = valid_q[set_idx] && (tag_q[set_idx] == addr_tag);
    assign last_word = (fill_cnt_q == WSEL_BITS'(WORDS_PER_LINE - 1));
    assign read_word = data_q[set_idx][word_sel];

    load_store_align u_align (
        .funct3     (cpu_ctrl),
        .byte_off   (cpu_addr[1:0]),
        .store_data (cpu_wdata),
        .read_word  (read_word),
        .wstrb      (st_wstrb),
        .wdata      (st_wdata),
        .load_data  (ld_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // The core holds cpu_* stable while stalled, so every mem_* output is a
    // function of state plus those inputs and stays stable through the ack.
    always_comb begin
        state_d   = state_q;
        stall     = 1'b0;
        cpu_rdata = '0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wstrb = '0;
        case (state_q)
            IDLE: begin
                if (cpu_req) begin
                    if (cpu_we) begin
                        stall   = 1'b1;
                        state_d = WRITE;
                    end else if (hit) begin
                        cpu_rdata = ld_data;
                    end else begin
                        stall   = 1'b1;
                        state_d = REFILL;
                    end
                end
            end
            REFILL: begin
                stall    = 1'b1;
                mem_req  = 1'b1;
                mem_addr = {addr_tag, set_idx, fill_cnt_q, {OFFSET_BITS{1'b0}}};
                if (mem_ack && last_word) begin
                    state_d = IDLE;
                end
            end
            WRITE: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {cpu_addr[ADDR_WIDTH-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
                mem_wdata = st_wdata;
                mem_wstrb = st_wstrb;
                // Release the pipeline in the ack cycle itself.
                stall     = ~mem_ack;
                if (mem_ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The line is invalidated when its refill starts, so a reset part way
    // through leaves nothing that could hit on partial data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q    <= '0;
            fill_cnt_q <= '0;
        end else begin
            if (state_q == IDLE && cpu_req && !cpu_we && !hit) begin
                valid_q[set_idx] <= 1'b0;
                fill_cnt_q       <= '0;
            end else if (state_q == REFILL && mem_ack) begin
                fill_cnt_q <= fill_cnt_q + WSEL_BITS'(1);
                if (last_word) begin
                    valid_q[set_idx] <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == REFILL && mem_ack) begin
            data_q[set_idx][fill_cnt_q] <= mem_rdata;
            if (last_word) begin
                tag_q[set_idx] <= addr_tag;
            end
        end else if (state_q == IDLE && cpu_req && cpu_we && hit) begin
            for (int b = 0; b < 4; b++) begin
                if (st_wstrb[b]) begin
                    data_q[set_idx][word_sel][8*b +: 8] <= st_wdata[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dcache_controller.sv
module tb_dcache_controller;
    import dcache_pkg::*;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [2:0]  cpu_ctrl = 3'b000;
    logic [31:0] cpu_addr = '0;
    logic [31:0] cpu_wdata = '0;
    logic [31:0] cpu_rdata;
    logic        stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;

    always #5 clk = ~clk;

    dcache_controller dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_ctrl  (cpu_ctrl),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .stall     (stall),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  strb;
        logic [31:0] data;
    } mem_txn_t;

    mem_txn_t    exp_mem[$];
    logic [31:0] exp_cpu[$];
    logic [31:0] mem [256];
    int n_checks = 0;
    int n_fail = 0;
    int ack_total = 0;
    int wait_cnt = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_rd(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            exp_mem.push_back('{we: 1'b0, addr: base + 32'(4 * i), strb: 4'b0000, data: 32'h0});
        end
    endtask

    task automatic push_wr(input logic [31:0] addr, input logic [3:0] strb, input logic [31:0] data);
        exp_mem.push_back('{we: 1'b1, addr: addr, strb: strb, data: data});
    endtask

    // Backing memory: acks in the (LAT+1)th cycle of each request and
    // checks every transaction against the expected queue.
    always @(posedge clk) begin
        mem_txn_t e;
        #1;
        if (!rst_n) begin
            mem_ack  = 1'b0;
            wait_cnt = 0;
        end else begin
            if (mem_ack) begin
                mem_ack  = 1'b0;
                wait_cnt = 0;
            end
            if (mem_req) begin
                wait_cnt++;
                if (wait_cnt == LAT + 1) begin
                    n_checks++;
                    if (exp_mem.size() == 0) begin
                        n_fail++;
                        $display("FAIL mem_unexpected: got we=%b addr=%h, expected no request", mem_we, mem_addr);
                    end else begin
                        e = exp_mem.pop_front();
                        if (mem_we !== e.we || mem_addr !== e.addr ||
                            (e.we && (mem_wstrb !== e.strb || mem_wdata !== e.data))) begin
                            n_fail++;
                            $display("FAIL mem_txn: got we=%b addr=%h strb=%b data=%h expected we=%b addr=%h strb=%b data=%h",
                                     mem_we, mem_addr, mem_wstrb, mem_wdata, e.we, e.addr, e.strb, e.data);
                        end
                    end
                    if (mem_we) begin
                        for (int b = 0; b < 4; b++) begin
                            if (mem_wstrb[b]) mem[mem_addr[9:2]][8*b +: 8] = mem_wdata[8*b +: 8];
                        end
                    end else begin
                        mem_rdata = mem[mem_addr[9:2]];
                    end
                    mem_ack = 1'b1;
                    ack_total++;
                end
            end
        end
    end

    // Core-side monitor: one result per completed access.
    always @(negedge clk) begin
        logic [31:0] e;
        if (rst_n && cpu_req && !stall) begin
            if (exp_cpu.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL cpu_unexpected: got completion rdata=%h, expected none", cpu_rdata);
            end else begin
                e = exp_cpu.pop_front();
                check32("cpu_rdata", cpu_rdata, e);
            end
        end
    end

    // Called at posedge+#1; returns at posedge+#1 after completion.
    task automatic access(input string name, input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] rdata_exp, input int stall_exp);
        int stalls = 0;
        bit done = 1'b0;
        exp_cpu.push_back(rdata_exp);
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_ctrl  = f3;
        cpu_addr  = addr;
        cpu_wdata = wdata;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (stall) stalls++;
            else done = 1'b1;
        end
        check32({name, "_done"}, 32'(done), 32'd1);
        check32({name, "_stall_cycles"}, 32'(stalls), 32'(stall_exp));
        @(posedge clk);
        #1;
        cpu_req = 1'b0;
        cpu_we  = 1'b0;
        check32({name, "_mem_left"}, 32'(exp_mem.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        int target;
        for (int i = 0; i < 256; i++) mem[i] = 32'hA5A5_0000 | 32'(i);
        mem[8'h40] = 32'h1111_1111;
        mem[8'h41] = 32'h2222_2222;
        mem[8'h42] = 32'h3333_3333;
        mem[8'h43] = 32'h4444_4444;

        #12;
        check32("rst_stall", 32'(stall), 32'd0);
        check32("rst_mem_req", 32'(mem_req), 32'd0);
        check32("rst_mem_we", 32'(mem_we), 32'd0);
        check32("rst_mem_addr", mem_addr, 32'h0);
        check32("rst_mem_wdata", mem_wdata, 32'h0);
        check32("rst_mem_wstrb", 32'(mem_wstrb), 32'h0);
        check32("rst_cpu_rdata", cpu_rdata, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        push_rd(32'h100, 4);
        access("lw100_miss", 1'b0, F3_W, 32'h100, 32'h0, 32'h1111_1111, 13);
        push_wr(32'h108, 4'b1111, 32'h8333_4455);
        access("sw108_hit", 1'b1, F3_W, 32'h108, 32'h8333_4455, 32'h0, 3);
        access("lb10b", 1'b0, F3_B, 32'h10B, 32'h0, 32'hFFFF_FF83, 0);
        access("lbu10b", 1'b0, F3_BU, 32'h10B, 32'h0, 32'h0000_0083, 0);
        access("lb108", 1'b0, F3_B, 32'h108, 32'h0, 32'h0000_0055, 0);
        access("lh10a", 1'b0, F3_H, 32'h10A, 32'h0, 32'hFFFF_8333, 0);

        push_wr(32'h104, 4'b1100, 32'hBEEF_BEEF);
        access("sh106", 1'b1, F3_H, 32'h106, 32'h1234_BEEF, 32'h0, 3);
        access("lhu106", 1'b0, F3_HU, 32'h106, 32'h0, 32'h0000_BEEF, 0);
        access("lh107", 1'b0, F3_H, 32'h107, 32'h0, 32'hFFFF_BEEF, 0);
        access("lw104", 1'b0, F3_W, 32'h104, 32'h0, 32'hBEEF_2222, 0);
        access("f3_111_105", 1'b0, 3'b111, 32'h105, 32'h0, 32'hBEEF_2222, 0);
        access("lb104", 1'b0, F3_B, 32'h104, 32'h0, 32'h0000_0022, 0);

        push_wr(32'h10C, 4'b0010, 32'h7F7F_7F7F);
        access("sb10d", 1'b1, F3_B, 32'h10D, 32'h0000_007F, 32'h0, 3);
        access("lw10c", 1'b0, F3_W, 32'h10C, 32'h0, 32'h4444_7F44, 0);

        push_wr(32'h200, 4'b1111, 32'hCAFE_F00D);
        access("sw200_miss", 1'b1, F3_W, 32'h200, 32'hCAFE_F00D, 32'h0, 3);
        push_rd(32'h200, 4);
        access("lw200_refill", 1'b0, F3_W, 32'h200, 32'h0, 32'hCAFE_F00D, 13);
        push_rd(32'h100, 4);
        access("lw104_conflict", 1'b0, F3_W, 32'h104, 32'h0, 32'hBEEF_2222, 13);
        push_rd(32'h200, 4);
        access("lw20c_conflict", 1'b0, F3_W, 32'h20C, 32'h0, 32'hA5A5_0083, 13);
        push_rd(32'h100, 4);
        access("lw10c_conflict", 1'b0, F3_W, 32'h10C, 32'h0, 32'h4444_7F44, 13);

        // Reset in the middle of a refill, right after the second word.
        push_rd(32'h300, 2);
        target    = ack_total + 2;
        cpu_req   = 1'b1;
        cpu_we    = 1'b0;
        cpu_ctrl  = F3_W;
        cpu_addr  = 32'h300;
        found     = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(posedge clk);
            #2;
            if (ack_total == target && !mem_ack) found = 1'b1;
        end
        check32("rst_mid_reached", 32'(found), 32'd1);
        check32("req_before_rst", 32'(mem_req), 32'd1);
        rst_n   = 1'b0;
        cpu_req = 1'b0;
        #1;
        check32("mid_rst_mem_req", 32'(mem_req), 32'd0);
        check32("mid_rst_mem_addr", mem_addr, 32'h0);
        check32("mid_rst_stall", 32'(stall), 32'd0);
        check32("mid_rst_mem_left", 32'(exp_mem.size()), 32'd0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        push_rd(32'h100, 4);
        access("lw100_after_rst", 1'b0, F3_W, 32'h100, 32'h0, 32'h1111_1111, 13);
        push_rd(32'h300, 4);
        access("lw308_after_rst", 1'b0, F3_W, 32'h308, 32'h0, 32'hA5A5_00C2, 13);
        check32("cpu_queue_left", 32'(exp_cpu.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
